// File: rtl/rw_responder_if.sv
// Request/response bundle for rw_responder: initiator drives requests, responder drives read data, stall and error.
interface rw_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              iWRITE;
  logic              iREAD;
  logic [ADDR_W-1:0] iADDRESS;
  logic [DATA_W-1:0] iWRITEDATA;
  logic [DATA_W-1:0] oREADDATA;
  logic              oREADDATAVALID;
  logic              oWAITREQUEST;
  logic              oPROT_ERR;

  modport master (
    output iWRITE, iREAD, iADDRESS, iWRITEDATA,
    input  oREADDATA, oREADDATAVALID, oWAITREQUEST, oPROT_ERR
  );

  modport slave (
    input  iWRITE, iREAD, iADDRESS, iWRITEDATA,
    output oREADDATA, oREADDATAVALID, oWAITREQUEST, oPROT_ERR
  );
endinterface

// File: rtl/rw_responder.sv
// Word memory responder: read data valid RD_LAT cycles after accept, writes land on the accepting edge.
// Stalls via oWAITREQUEST for REF_CYCLES every REF_PERIOD idle cycles; RW_RESP_ERR_INJECT_EN flips bit 0 on reads of 0x05.
module rw_responder #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 2,
  parameter int REF_PERIOD = 64,
  parameter int REF_CYCLES = 4
) (
  input logic          iCLK,
  input logic          iRST,
  rw_responder_if.slave bus
);
  localparam int CNT_W = (REF_PERIOD > 2) ? $clog2(REF_PERIOD) : 1;

  typedef enum logic {IDLE, REFRESH} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wait_q;
  logic              prot_q;
  logic              acc, wr_acc, rd_acc;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [RD_LAT-1:0] vld_sr;
  logic [DATA_W-1:0] dat_sr [RD_LAT];

  assign acc    = ~iRST & ~wait_q & (bus.iWRITE | bus.iREAD);
  assign wr_acc = acc & bus.iWRITE;
  assign rd_acc = acc & bus.iREAD & ~bus.iWRITE;

  // One counter serves both the idle interval and the stall length.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (cnt == CNT_W'(REF_PERIOD - 1)) begin
          cnt_nxt   = '0;
          state_nxt = REFRESH;
        end
      end
      REFRESH: begin
        if (cnt == CNT_W'(REF_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state  <= IDLE;
      cnt    <= '0;
      wait_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      wait_q <= (state_nxt == REFRESH);
    end
  end

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge iCLK) begin
    if (wr_acc)
      mem[bus.iADDRESS] <= bus.iWRITEDATA;
  end

`ifdef RW_RESP_ERR_INJECT_EN
  assign rd_word = mem[bus.iADDRESS]
                 ^ {{(DATA_W-1){1'b0}}, (bus.iADDRESS == ADDR_W'(5))};
`else
  assign rd_word = mem[bus.iADDRESS];
`endif

  // Data stages only advance behind a valid, so the last stage holds between pulses.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      vld_sr <= '0;
      prot_q <= 1'b0;
      for (int i = 0; i < RD_LAT; i++)
        dat_sr[i] <= '0;
    end else begin
      vld_sr[0] <= rd_acc;
      if (rd_acc)
        dat_sr[0] <= rd_word;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        if (vld_sr[i-1])
          dat_sr[i] <= dat_sr[i-1];
      end
      prot_q <= prot_q | (wr_acc & bus.iREAD);
    end
  end

  assign bus.oREADDATA      = dat_sr[RD_LAT-1];
  assign bus.oREADDATAVALID = vld_sr[RD_LAT-1];
  assign bus.oWAITREQUEST   = wait_q;
  assign bus.oPROT_ERR      = prot_q;
endmodule

// File: tb/tb_rw_responder.sv
// Directed bench for rw_responder: reference memory plus read scoreboard, refresh window model, reset flush.
module tb_rw_responder;
  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 16;
  localparam int RD_LAT     = 2;
  localparam int REF_PERIOD = 64;
  localparam int REF_CYCLES = 4;

  logic clk = 1'b0;
  logic rst;

  rw_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  rw_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT),
    .REF_PERIOD(REF_PERIOD), .REF_CYCLES(REF_CYCLES)
  ) dut (
    .iCLK(clk),
    .iRST(rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] dat;
    int                due;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] mem_m [2**ADDR_W];
  int                cyc = 0;
  int                rst_edge = 0;
  int                n_chk = 0;
  int                n_pass = 0;
  int                n_fail = 0;
  bit                rst_on = 1'b1;
  bit                prot_m = 1'b0;
  logic [DATA_W-1:0] last_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Refresh timing model: counted in edges since the last reset edge.
  function automatic bit exp_wait();
    if (rst_on) return 1'b0;
    return ((cyc - rst_edge) % (REF_PERIOD + REF_CYCLES)) >= REF_PERIOD;
  endfunction

  function automatic logic [DATA_W-1:0] rd_exp(logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = mem_m[a];
`ifdef RW_RESP_ERR_INJECT_EN
    if (a == 8'h05) d[0] = ~d[0];
`endif
    return d;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_on)
      chk("waitrequest", 32'(bus.oWAITREQUEST), 32'(exp_wait()));
    if (bus.oREADDATAVALID === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(bus.oREADDATAVALID), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rd_data", 32'(bus.oREADDATA), 32'(e.dat));
        chk("rd_cycle", cyc, e.due);
        last_dat = e.dat;
      end
    end else if (!rst_on) begin
      chk("rd_hold", 32'(bus.oREADDATA), 32'(last_dat));
    end
  end

  task automatic drive(bit w, bit r, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bus.iWRITE     = w;
    bus.iREAD      = r;
    bus.iADDRESS   = a;
    bus.iWRITEDATA = d;
  endtask

  // Presents the request each cycle until the model says it is accepted.
  task automatic req(bit w, bit r, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    bit   done;
    exp_t e;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      drive(w, r, a, d);
      if (!exp_wait()) begin
        done = 1'b1;
        if (w) mem_m[a] = d;
        if (w && r) prot_m = 1'b1;
        if (r && !w) begin
          e.dat = rd_exp(a);
          e.due = cyc + RD_LAT;
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      drive(1'b0, 1'b0, '0, '0);
    end
  endtask

  task automatic drain(string tag);
    idle(RD_LAT + 3);
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    rst_on = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_readdata", 32'(bus.oREADDATA), 32'd0);
    chk("rst_valid", 32'(bus.oREADDATAVALID), 32'd0);
    chk("rst_wait", 32'(bus.oWAITREQUEST), 32'd0);
    chk("rst_prot", 32'(bus.oPROT_ERR), 32'd0);
    rst      = 1'b0;
    rst_edge = cyc;
    rst_on   = 1'b0;
    prot_m   = 1'b0;
    last_dat = '0;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    do_reset();

    // Write then read the same address on the next edge.
    req(1'b1, 1'b0, 8'h10, 16'hA5C3);
    req(1'b0, 1'b1, 8'h10, '0);
    drain("drain_basic");

    // Fill memory with address = data, then stream reads across refresh stalls.
    for (int i = 0; i < 256; i++) req(1'b1, 1'b0, i[7:0], 16'(i));
    for (int i = 0; i < 256; i++) req(1'b0, 1'b1, i[7:0], '0);
    drain("drain_stream");

    // Continuous reads from reset; the monitor checks the stall window every cycle.
    do_reset();
    for (int i = 0; i < 150; i++) req(1'b0, 1'b1, 8'(i * 3), '0);
    drain("drain_refresh");

    // Simultaneous write+read: write lands, read dropped, sticky error.
    chk("prot_before", 32'(bus.oPROT_ERR), 32'(prot_m));
    req(1'b1, 1'b1, 8'h20, 16'h1234);
    idle(4);
    chk("prot_set", 32'(bus.oPROT_ERR), 32'(prot_m));
    req(1'b0, 1'b1, 8'h20, '0);
    idle(20);
    chk("prot_held", 32'(bus.oPROT_ERR), 32'(prot_m));
    drain("drain_prot");

    // Injection target, its neighbour, all-ones address, and overwrite-then-read.
    req(1'b1, 1'b0, 8'h05, 16'h00F0);
    req(1'b0, 1'b1, 8'h05, '0);
    req(1'b1, 1'b0, 8'h06, 16'h0066);
    req(1'b0, 1'b1, 8'h06, '0);
    req(1'b1, 1'b0, 8'hFF, 16'hBEEF);
    req(1'b0, 1'b1, 8'hFF, '0);
    req(1'b1, 1'b0, 8'h10, 16'h5A5A);
    req(1'b0, 1'b1, 8'h10, '0);
    req(1'b0, 1'b1, 8'h05, '0);
    drain("drain_misc");

    // Read in flight when reset asserts must never surface.
    req(1'b0, 1'b1, 8'h33, '0);
    do_reset();
    idle(RD_LAT + 6);
    chk("flush_prot", 32'(bus.oPROT_ERR), 32'd0);
    chk("flush_sb", sb.size(), 0);

    // Memory survives reset.
    req(1'b0, 1'b1, 8'h20, '0);
    drain("drain_after_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rw_responder.md
RW_RESPONDER -- requirements
Module: rw_responder

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 8, meaning the address width (2^ADDR_W words of storage).
REQ-002 The block SHALL have the parameter DATA_W, default 16, meaning the data word width.
REQ-003 The block SHALL have the parameter RD_LAT, default 2, legal 1..4, meaning the cycles from read accept to read data valid.
REQ-004 The block SHALL have the parameter REF_PERIOD, default 64, meaning the cycles between refresh stalls.
REQ-005 The block SHALL have the parameter REF_CYCLES, default 4, legal 1..REF_PERIOD-1, meaning the length of each refresh stall in cycles.
REQ-006 The block SHALL have the port iCLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have the port iRST, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have the port iWRITE, input, 1 bit: write request.
REQ-009 The block SHALL have the port iREAD, input, 1 bit: read request.
REQ-010 The block SHALL have the port iADDRESS, input, ADDR_W bits: request address.
REQ-011 The block SHALL have the port iWRITEDATA, input, DATA_W bits: write data.
REQ-012 The block SHALL have the port oREADDATA, output, DATA_W bits, registered: read data.
REQ-013 The block SHALL have the port oREADDATAVALID, output, 1 bit, registered: one-cycle pulse qualifying oREADDATA.
REQ-014 The block SHALL have the port oWAITREQUEST, output, 1 bit, registered: when high, requests are not accepted.
REQ-015 The block SHALL have the port oPROT_ERR, output, 1 bit, registered: sticky protocol-error flag.

Function
REQ-016 The block SHALL accept a request at a rising edge only when iWRITE or iREAD is high and oWAITREQUEST is low; requests presented while oWAITREQUEST is high are ignored and have no side effect.
REQ-017 The block SHALL write iWRITEDATA to mem[iADDRESS] at the edge on which a write is accepted.
REQ-018 The block SHALL present mem[iADDRESS] on oREADDATA, with oREADDATAVALID high for exactly one cycle, RD_LAT cycles after the accepting edge of a read.
REQ-019 The block SHALL pipeline reads: it SHALL accept one read per cycle, and valid pulses SHALL follow in order with no gaps relative to the accepts.
REQ-020 A read accepted on the edge immediately after a write to the same address SHALL return the newly written data.
REQ-021 When iWRITE and iREAD are high together at an accepting edge, the write SHALL be performed, the read SHALL be dropped, and oPROT_ERR SHALL be set.
REQ-022 oPROT_ERR SHALL remain set until reset.
REQ-023 The FSM SHALL have the states IDLE and REFRESH.
REQ-024 In IDLE, the refresh counter SHALL increment every cycle; at count REF_PERIOD-1 the counter SHALL clear and the FSM SHALL go to REFRESH.
REQ-025 In REFRESH, oWAITREQUEST SHALL be high for exactly REF_CYCLES cycles, after which the FSM SHALL return to IDLE with oWAITREQUEST low.
REQ-026 oWAITREQUEST SHALL go high on the cycle after the edge on which the counter reaches REF_PERIOD-1; a request accepted on that edge SHALL complete normally.
REQ-027 Reads already in the latency pipeline SHALL complete on schedule during REFRESH.
REQ-028 oREADDATA SHALL hold its last value while oREADDATAVALID is low.
REQ-029 Address arithmetic SHALL not wrap: iADDRESS is used directly, and an address of all-ones SHALL be a legal address.
REQ-030 Reading a location never written since power-up SHALL return an undefined value.

Reset
REQ-031 While iRST is high at an edge, the block SHALL drive oREADDATA = 0, oREADDATAVALID = 0, oWAITREQUEST = 0 and oPROT_ERR = 0.
REQ-032 While iRST is high at an edge, the FSM SHALL be in IDLE and the refresh counter SHALL be 0.
REQ-033 Reset SHALL flush the read pipeline: any read in flight when reset asserts SHALL never produce a valid pulse.
REQ-034 Reset SHALL not alter memory contents.
REQ-035 Requests presented while iRST is high SHALL be ignored.

Configuration
REQ-036 With RW_RESP_ERR_INJECT_EN defined, a read of address 0x05 SHALL return the stored data with bit 0 inverted, so that an initiator's fail path can be exercised.
REQ-037 Without RW_RESP_ERR_INJECT_EN defined, all reads SHALL return the stored data unmodified, and no injection logic SHALL be present.

Verification
REQ-038 Scenario: reset, write 0xA5C3 to 0x10, read 0x10 on the next edge -> oREADDATAVALID pulses 2 cycles after the read accept with oREADDATA = 0xA5C3.
REQ-039 Scenario: write 0x0000..0x00FF to addresses 0..255 (address = data), then issue 256 back-to-back reads -> 256 consecutive valid pulses with data equal to address, in order, except where refresh stalls interleave.
REQ-040 Scenario: from reset, hold iREAD high continuously -> oWAITREQUEST is high on cycles 65..68, no accepts occur in that window, and the pipelined reads issued before it still return their valid pulses.
REQ-041 Scenario: iWRITE = iREAD = 1 at address 0x20 with data 0x1234 -> mem[0x20] = 0x1234, no valid pulse, oPROT_ERR = 1 and held until iRST.
REQ-042 Scenario: accept a read, then assert iRST one cycle later -> no oREADDATAVALID pulse ever appears, and all outputs are 0 after the reset edge.
REQ-043 Scenario: with RW_RESP_ERR_INJECT_EN defined, write 0x00F0 to 0x05 and read it back -> 0x00F1; write and read 0x06 -> unmodified value returned.
